// File: rtl/div_iter.sv
// Multi-cycle restoring divider producing STEPS quotient bits per clock, signed or unsigned.
// Define DIV_ZERO_FAST_EN to finish a zero-divisor request in one cycle instead of iterating.
module div_iter #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_by_zero_o
);

    localparam int CNT_W = $clog2(WIDTH / STEPS + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] dvd_raw;
    logic             q_neg;
    logic             r_neg;
    logic             zero_div;

    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             accept;

    // The most negative value negates to itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    assign accept = (state == S_IDLE) && start_i && !annul_i;
    assign busy_o  = (state == S_BUSY);
    assign ready_o = (state == S_DONE);

    // STEPS restoring shift/subtract steps, MSB first; quo shifts dividend bits out as quotient bits enter.
    always_comb begin
        quo_n = quo;
        rem_n = rem;
        trial = '0;
        for (int i = 0; i < STEPS; i++) begin
            trial = {rem_n, quo_n[WIDTH-1]};
            quo_n = {quo_n[WIDTH-2:0], 1'b0};
            if (trial >= {1'b0, dvs}) begin
                rem_n    = trial[WIDTH-1:0] - dvs;
                quo_n[0] = 1'b1;
            end else begin
                rem_n = trial[WIDTH-1:0];
            end
        end
        q_fix = q_neg ? -quo_n : quo_n;
        r_fix = r_neg ? -rem_n : rem_n;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            dvd_raw  <= opdata1_i;
            quo      <= magnitude(opdata1_i, signed_div_i);
            dvs      <= magnitude(opdata2_i, signed_div_i);
            rem      <= '0;
            q_neg    <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_neg    <= signed_div_i && opdata1_i[WIDTH-1];
            zero_div <= (opdata2_i == '0);
        end else if (state == S_BUSY) begin
            quo <= quo_n;
            rem <= rem_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            result_o      <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        div_by_zero_o <= 1'b0;
                        cnt           <= CNT_W'(WIDTH / STEPS);
`ifdef DIV_ZERO_FAST_EN
                        if (opdata2_i == '0) begin
                            state         <= S_DONE;
                            result_o      <= {opdata1_i, {WIDTH{1'b1}}};
                            div_by_zero_o <= 1'b1;
                        end else begin
                            state <= S_BUSY;
                        end
`else
                        state <= S_BUSY;
`endif
                    end
                end
                S_BUSY: begin
                    if (annul_i) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state         <= S_DONE;
                            result_o      <= zero_div ? {dvd_raw, {WIDTH{1'b1}}} : {r_fix, q_fix};
                            div_by_zero_o <= zero_div;
                        end
                    end
                end
                S_DONE: begin
                    if (annul_i || !start_i) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: a 32-bit radix-2 instance plus 16-bit instances at STEPS=2 and STEPS=4.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div, start, annul;
    logic [31:0] op1, op2;
    logic [63:0] result;
    logic        ready, busy, dbz;

    logic        sig16, start16;
    logic [15:0] a16, b16;
    logic [31:0] res_s2, res_s4;
    logic        rdy_s2, rdy_s4, busy_s2, busy_s4, dbz_s2, dbz_s4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(32), .STEPS(1)) u_dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready), .busy_o(busy),
        .div_by_zero_o(dbz)
    );

    div_iter #(.WIDTH(16), .STEPS(2)) u_s2 (
        .clk(clk), .rst(rst), .signed_div_i(sig16), .opdata1_i(a16), .opdata2_i(b16),
        .start_i(start16), .annul_i(1'b0), .result_o(res_s2), .ready_o(rdy_s2), .busy_o(busy_s2),
        .div_by_zero_o(dbz_s2)
    );

    div_iter #(.WIDTH(16), .STEPS(4)) u_s4 (
        .clk(clk), .rst(rst), .signed_div_i(sig16), .opdata1_i(a16), .opdata2_i(b16),
        .start_i(start16), .annul_i(1'b0), .result_o(res_s4), .ready_o(rdy_s4), .busy_o(busy_s4),
        .div_by_zero_o(dbz_s4)
    );

    // Called at a negedge; returns at the negedge where ready is first seen (or after 200 edges).
    task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat, output int bcyc);
        signed_div = s; op1 = a; op2 = b; start = 1'b1;
        lat = 0; bcyc = 0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (busy) bcyc++;
        end while (!ready && lat < 200);
        res = result;
    endtask

    task automatic release32();
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        start16 = 1'b0; sig16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (result !== 64'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
        n_vec++; if (ready !== 1'b0 || busy !== 1'b0 || dbz !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: got rdy=%b busy=%b dbz=%b want 0 0 0", ready, busy, dbz);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [63:0] res; int lat, bcyc;
        run32(1'b0, 32'd100, 32'd7, res, lat, bcyc);
        n_vec++; if (res !== {32'd2, 32'd14}) begin n_err++; $display("FAIL u100_7: got %h want %h", res, {32'd2, 32'd14}); end
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL u100_7_latency: got %0d want 33", lat); end
        n_vec++; if (bcyc !== 32) begin n_err++; $display("FAIL u100_7_busy_cycles: got %0d want 32", bcyc); end
        @(posedge clk); @(negedge clk);
        n_vec++; if (ready !== 1'b1 || result !== {32'd2, 32'd14}) begin
            n_err++; $display("FAIL done_hold: got rdy=%b res=%h want 1 %h", ready, result, {32'd2, 32'd14});
        end
        release32();
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL ready_fall: got %b want 0", ready); end
    endtask

    task automatic test_signed();
        logic [63:0] res; int lat, bcyc;
        run32(1'b1, 32'hFFFF_FFF9, 32'd2, res, lat, bcyc);
        n_vec++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_err++; $display("FAIL s_m7_2: got %h want ffffffff_fffffffd", res); end
        release32();
        run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bcyc);
        n_vec++; if (res !== {32'd0, 32'h8000_0000}) begin n_err++; $display("FAIL s_min_m1: got %h want 00000000_80000000", res); end
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL s_min_m1_latency: got %0d want 33", lat); end
        release32();
        run32(1'b0, 32'hFFFF_FFFF, 32'h10, res, lat, bcyc);
        n_vec++; if (res !== {32'hF, 32'h0FFF_FFFF}) begin n_err++; $display("FAIL u_max_16: got %h want 0000000f_0fffffff", res); end
        release32();
        run32(1'b0, 32'hFFFF_FFF9, 32'd2, res, lat, bcyc);
        n_vec++; if (res !== {32'd1, 32'h7FFF_FFFC}) begin n_err++; $display("FAIL u_fff9_2: got %h want 00000001_7ffffffc", res); end
        release32();
    endtask

    task automatic test_div_zero();
        logic [63:0] res; int lat, bcyc;
        int exp_lat, exp_bcyc;
`ifdef DIV_ZERO_FAST_EN
        exp_lat = 1; exp_bcyc = 0;
`else
        exp_lat = 33; exp_bcyc = 32;
`endif
        run32(1'b0, 32'd5, 32'd0, res, lat, bcyc);
        n_vec++; if (res !== {32'd5, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL dz_u5: got %h want 00000005_ffffffff", res); end
        n_vec++; if (dbz !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b want 1", dbz); end
        n_vec++; if (lat !== exp_lat || bcyc !== exp_bcyc) begin
            n_err++; $display("FAIL dz_latency: got lat=%0d busy=%0d want %0d %0d", lat, bcyc, exp_lat, exp_bcyc);
        end
        release32();
        run32(1'b1, 32'hFFFF_FFFB, 32'd0, res, lat, bcyc);
        n_vec++; if (res !== {32'hFFFF_FFFB, 32'hFFFF_FFFF} || dbz !== 1'b1) begin
            n_err++; $display("FAIL dz_sm5: got %h dbz=%b want fffffffb_ffffffff 1", res, dbz);
        end
        release32();
        run32(1'b0, 32'd9, 32'd3, res, lat, bcyc);
        n_vec++; if (res !== {32'd0, 32'd3} || dbz !== 1'b0) begin
            n_err++; $display("FAIL dz_clear_9_3: got %h dbz=%b want 00000000_00000003 0", res, dbz);
        end
        release32();
    endtask

    task automatic test_annul();
        logic [63:0] res; int lat, bcyc;
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1; op1 = 32'd20; op2 = 32'd6;
        @(posedge clk); @(negedge clk);
        n_vec++; if (ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL annul_flags: got rdy=%b busy=%b want 0 0", ready, busy); end
        n_vec++; if (result !== {32'd0, 32'd3}) begin n_err++; $display("FAIL annul_result: got %h want 00000000_00000003", result); end
        annul = 1'b0;
        run32(1'b0, 32'd20, 32'd6, res, lat, bcyc);
        n_vec++; if (res !== {32'd2, 32'd3} || lat !== 33) begin
            n_err++; $display("FAIL annul_restart: got %h lat=%0d want 00000002_00000003 33", res, lat);
        end
        release32();
        // Annul arriving in IDLE together with start must keep the block idle.
        annul = 1'b1; start = 1'b1; op1 = 32'd50; op2 = 32'd5;
        @(posedge clk); @(negedge clk);
        n_vec++; if (busy !== 1'b0 || ready !== 1'b0) begin n_err++; $display("FAIL annul_idle: got busy=%b rdy=%b want 0 0", busy, ready); end
        annul = 1'b0; start = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_operand_hold();
        int lat = 0;
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
            op1 = $urandom(); op2 = $urandom(); signed_div = 1'($urandom());
        end while (!ready && lat < 200);
        n_vec++; if (result !== {32'd6, 32'd142} || lat !== 33) begin
            n_err++; $display("FAIL operand_hold: got %h lat=%0d want 00000006_0000008e 33", result, lat);
        end
        release32();
    endtask

    task automatic test_reset_mid();
        logic [63:0] res; int lat, bcyc;
        run32(1'b0, 32'd7, 32'd0, res, lat, bcyc);
        rst = 1'b1; start = 1'b0;
        @(posedge clk); @(negedge clk);
        n_vec++; if (result !== 64'd0 || ready !== 1'b0 || dbz !== 1'b0) begin
            n_err++; $display("FAIL rst_done: got res=%h rdy=%b dbz=%b want 0 0 0", result, ready, dbz);
        end
        rst = 1'b0;
        run32(1'b0, 32'd100, 32'd7, res, lat, bcyc);
        release32();
        signed_div = 1'b0; op1 = 32'd77; op2 = 32'd5; start = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(posedge clk); @(negedge clk);
        n_vec++; if (result !== 64'd0 || ready !== 1'b0 || busy !== 1'b0 || dbz !== 1'b0) begin
            n_err++; $display("FAIL rst_busy: got res=%h rdy=%b busy=%b dbz=%b want 0 0 0 0", result, ready, busy, dbz);
        end
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_w16();
        logic        sv [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] av [6] = '{16'd1000, 16'hFC18, 16'd1000, 16'h8000, 16'hFFFF, 16'hFFF7};
        logic [15:0] bv [6] = '{16'd7, 16'd7, 16'hFFF9, 16'hFFFF, 16'h0100, 16'hFFFC};
        logic [31:0] ev [6] = '{{16'd6, 16'd142}, {16'hFFFA, 16'hFF72}, {16'd6, 16'hFF72},
                                {16'd0, 16'h8000}, {16'h00FF, 16'h00FF}, {16'hFFFF, 16'd2}};
        for (int v = 0; v < 6; v++) begin
            int lat = 0, lat2 = 0, lat4 = 0;
            sig16 = sv[v]; a16 = av[v]; b16 = bv[v]; start16 = 1'b1;
            do begin
                @(posedge clk); lat++;
                @(negedge clk);
                if (rdy_s2 && lat2 == 0) lat2 = lat;
                if (rdy_s4 && lat4 == 0) lat4 = lat;
            end while (!(rdy_s2 && rdy_s4) && lat < 100);
            n_vec++; if (res_s2 !== ev[v] || lat2 !== 9) begin
                n_err++; $display("FAIL w16_s2_vec%0d: got %h lat=%0d want %h 9", v, res_s2, lat2, ev[v]);
            end
            n_vec++; if (res_s4 !== ev[v] || lat4 !== 5) begin
                n_err++; $display("FAIL w16_s4_vec%0d: got %h lat=%0d want %h 5", v, res_s4, lat4, ev[v]);
            end
            start16 = 1'b0;
            @(posedge clk); @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_operand_hold();
        test_reset_mid();
        test_w16();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
